// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path and its scheduler.
// The encode control path imports the same frame-length and baud limits.
package uart_pkg;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 10;
    localparam int BAUD_W = 20;

    localparam logic [BAUD_W-1:0] MIN_BAUD = 20'd15;
    localparam logic [CNT_W-1:0]  END_CNT  = 10'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    function automatic logic baud_legal(input logic [BAUD_W-1:0] b);
        return b >= MIN_BAUD;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester, baud-configuration and transmitter-facing signals of the scheduler.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface uart_tx_sched_if #(parameter int N_REQ = 4) ();
    import uart_pkg::*;

    logic                    enable;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] din;
    logic [N_REQ-1:0]        gnt;
    logic [BAUD_W-1:0]       baud_cfg;
    logic                    baud_ld;
    logic                    baud_err;
    logic                    busy;
    logic                    tx_sel;
    logic                    tx_set;
    logic [DATA_W-1:0]       tx_din;
    logic [BAUD_W-1:0]       tx_baud;
    logic                    tx_en;
    logic [CNT_W-1:0]        bit_cnt;

    modport slave (
        input  enable, req, din, baud_cfg, baud_ld, tx_en, bit_cnt,
        output gnt, baud_err, busy, tx_sel, tx_set, tx_din, tx_baud
    );

    modport master (
        output enable, req, din, baud_cfg, baud_ld, tx_en, bit_cnt,
        input  gnt, baud_err, busy, tx_sel, tx_set, tx_din, tx_baud
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Done with a mask-then-lowest-bit trick so no variable indexing is needed.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic             any
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] pick;

    always_comb begin
        mask   = ~((N_REQ'(1) << ptr) - N_REQ'(1));
        masked = req & mask;
        pick   = (masked != '0) ? masked : req;
        win    = pick & (~pick + N_REQ'(1));
        any    = |req;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ word sources,
// sequencing one full frame per grant and owning the baud divisor register.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);

    localparam int PTR_W = $clog2(N_REQ);

    sched_state_e      state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0] tx_din_q, tx_din_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic [BAUD_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              baud_err_q, baud_err_d;

    logic [N_REQ-1:0]  win;
    logic              any;
    logic [PTR_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_word;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .win (win),
        .any (any)
    );

    always_comb begin
        win_idx  = '0;
        win_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PTR_W'(i);
                win_word = bus.din[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration is resolved on the IDLE->GRANT edge so gnt and tx_din are valid together.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = '0;
        tx_din_d   = tx_din_q;
        tx_baud_d  = tx_baud_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        baud_err_d = baud_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.baud_ld) begin
                    tx_baud_d  = bus.baud_cfg;
                    baud_err_d = !baud_legal(bus.baud_cfg);
                end else if (bus.enable && baud_legal(tx_baud_q) && any) begin
                    state_d  = ST_GRANT;
                    gnt_d    = win;
                    tx_din_d = win_word;
                    rr_ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                end
            end
            ST_GRANT, ST_SEND: begin
                if (bus.baud_ld) begin
                    pend_d     = bus.baud_cfg;
                    pend_vld_d = 1'b1;
                end
                if (!bus.enable) begin
                    state_d = ST_GAP;
                end else if (state_q == ST_GRANT) begin
                    state_d = ST_SEND;
                end else if (bus.bit_cnt == END_CNT && !bus.tx_en) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d    = ST_IDLE;
                pend_vld_d = 1'b0;
                if (bus.baud_ld) begin
                    tx_baud_d  = bus.baud_cfg;
                    baud_err_d = !baud_legal(bus.baud_cfg);
                end else if (pend_vld_q) begin
                    tx_baud_d  = pend_q;
                    baud_err_d = !baud_legal(pend_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            tx_din_q   <= '0;
            tx_baud_q  <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            baud_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            tx_din_q   <= tx_din_d;
            tx_baud_q  <= tx_baud_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            baud_err_q <= baud_err_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.tx_baud  = tx_baud_q;
    assign bus.baud_err = baud_err_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.tx_set   = (state_q == ST_SEND);
    assign bus.tx_sel   = bus.enable;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a behavioural transmitter drives bit_cnt/tx_en,
// and grant order is predicted by a modular-arithmetic round-robin model.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int N      = 4;
    localparam int BUDGET = 300;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   ptr_m;

    uart_tx_sched_if #(.N_REQ(N)) ifc ();

    uart_tx_sched #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter: counts bits while tx_set is high, with random baud stalls.
    initial begin : xmit_model
        ifc.tx_en   = 1'b0;
        ifc.bit_cnt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!ifc.tx_set) begin
                ifc.tx_en   = 1'b0;
                ifc.bit_cnt = '0;
            end else if (ifc.bit_cnt < END_CNT) begin
                ifc.tx_en = 1'b1;
                if ($urandom_range(0, 3) != 0) ifc.bit_cnt = ifc.bit_cnt + 10'd1;
                if (ifc.bit_cnt == END_CNT) ifc.tx_en = 1'($urandom_range(0, 1));
            end else begin
                ifc.tx_en = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic load_baud(input logic [BAUD_W-1:0] v);
        @(negedge clk);
        ifc.baud_cfg = v;
        ifc.baud_ld  = 1'b1;
        @(negedge clk);
        ifc.baud_ld  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        ifc.req = '0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output bit ok, output logic prev_busy);
        logic pb;
        ok        = 1'b0;
        g         = '0;
        prev_busy = 1'b0;
        pb        = ifc.busy;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (ifc.gnt != '0) begin
                g         = ifc.gnt;
                ok        = 1'b1;
                prev_busy = pb;
                break;
            end
            pb = ifc.busy;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (!ifc.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        ifc.enable   = 1'b0;
        ifc.req      = '0;
        ifc.din      = '0;
        ifc.baud_cfg = '0;
        ifc.baud_ld  = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ifc.gnt !== '0)      begin bad++; $display("FAIL reset_gnt: got %b want 0", ifc.gnt); end
        total++; if (ifc.busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
        total++; if (ifc.tx_set !== 1'b0) begin bad++; $display("FAIL reset_tx_set: got %b want 0", ifc.tx_set); end
        total++; if (ifc.tx_din !== '0)   begin bad++; $display("FAIL reset_tx_din: got %h want 0", ifc.tx_din); end
        total++; if (ifc.tx_baud !== '0)  begin bad++; $display("FAIL reset_tx_baud: got %0d want 0", ifc.tx_baud); end
        total++; if (ifc.baud_err !== 1'b0) begin bad++; $display("FAIL reset_baud_err: got %b want 0", ifc.baud_err); end
        total++; if (ifc.tx_sel !== 1'b0) begin bad++; $display("FAIL reset_tx_sel_lo: got %b want 0", ifc.tx_sel); end
        ifc.enable = 1'b1;
        #1;
        total++; if (ifc.tx_sel !== 1'b1) begin bad++; $display("FAIL reset_tx_sel_hi: got %b want 1", ifc.tx_sel); end
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_baud_err();
        logic [DATA_W-1:0] w0;
        bit seen;
        bit ok;
        ifc.din = (N*DATA_W)'({$urandom(), $urandom()});
        w0      = ifc.din[DATA_W-1:0];
        load_baud(20'd10);
        total++; if (ifc.baud_err !== 1'b1) begin bad++; $display("FAIL berr_set: got %b want 1", ifc.baud_err); end
        total++; if (ifc.tx_baud !== 20'd10) begin bad++; $display("FAIL berr_baud10: got %0d want 10", ifc.tx_baud); end
        ifc.req = 4'b0001;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ifc.gnt != '0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL berr_no_gnt: got grant want none"); end
        load_baud(20'd16);
        total++; if (ifc.baud_err !== 1'b0) begin bad++; $display("FAIL berr_clear: got %b want 0", ifc.baud_err); end
        @(negedge clk);
        total++; if (ifc.gnt !== 4'b0001) begin bad++; $display("FAIL berr_first_gnt: got %b want 0001", ifc.gnt); end
        total++; if (ifc.tx_din !== w0)   begin bad++; $display("FAIL berr_tx_din: got %h want %h", ifc.tx_din, w0); end
        ptr_m   = 1;
        ifc.req = '0;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL berr_idle: busy stuck at %b want 0", ifc.busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, eg;
        logic [DATA_W-1:0] ew;
        logic pb;
        bit ok;
        int e;
        do_reset();
        load_baud(20'd16);
        ifc.din = {10'h2AA, 10'h155, 10'h0F0, 10'h3A5};
        ifc.req = 4'b1111;
        for (int f = 0; f < 4; f++) begin
            e  = model_pick(ifc.req, ptr_m);
            eg = '0;
            eg[e] = 1'b1;
            ew = ifc.din[e*DATA_W +: DATA_W];
            wait_gnt(g, ok, pb);
            total++; if (!ok) begin bad++; $display("FAIL rr_gnt_timeout f%0d: got none want %b", f, eg); end
            total++; if (g !== eg) begin bad++; $display("FAIL rr_gnt f%0d: got %b want %b", f, g, eg); end
            total++; if (ifc.tx_din !== ew) begin bad++; $display("FAIL rr_tx_din f%0d: got %h want %h", f, ifc.tx_din, ew); end
            total++; if (pb !== 1'b0) begin bad++; $display("FAIL rr_gnt_while_busy f%0d: busy %b want 0", f, pb); end
            ptr_m      = (e + 1) % N;
            ifc.req[e] = 1'b0;
            @(negedge clk);
            total++; if (ifc.tx_set !== 1'b1) begin bad++; $display("FAIL rr_tx_set_rise f%0d: got %b want 1", f, ifc.tx_set); end
            ok = 1'b0;
            for (int c = 0; c < BUDGET; c++) begin
                if (ifc.bit_cnt == END_CNT && !ifc.tx_en) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            total++; if (!ok) begin bad++; $display("FAIL rr_frame_end f%0d: bit_cnt %0d want 12", f, ifc.bit_cnt); end
            @(negedge clk);
            total++; if (ifc.tx_set !== 1'b0 || ifc.busy !== 1'b1) begin
                bad++; $display("FAIL rr_gap f%0d: tx_set/busy %b%b want 01", f, ifc.tx_set, ifc.busy);
            end
            @(negedge clk);
            total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rr_busy_fall f%0d: got %b want 0", f, ifc.busy); end
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] g, eg;
        logic [DATA_W-1:0] ew;
        logic pb;
        bit ok;
        int e;
        ifc.din = (N*DATA_W)'({$urandom(), $urandom()});
        ifc.req = 4'b1001;
        for (int f = 0; f < 4; f++) begin
            e  = model_pick(ifc.req, ptr_m);
            eg = '0;
            eg[e] = 1'b1;
            ew = ifc.din[e*DATA_W +: DATA_W];
            wait_gnt(g, ok, pb);
            total++; if (!ok || g !== eg) begin bad++; $display("FAIL wrap_gnt f%0d: got %b want %b", f, g, eg); end
            total++; if (ifc.tx_din !== ew) begin bad++; $display("FAIL wrap_tx_din f%0d: got %h want %h", f, ifc.tx_din, ew); end
            ptr_m = (e + 1) % N;
        end
        ifc.req = '0;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_idle: busy %b want 0", ifc.busy); end
    endtask

    task automatic test_random();
        logic [N-1:0] g, eg;
        logic [DATA_W-1:0] ew;
        logic pb;
        bit ok;
        int e;
        ifc.req = N'($urandom_range(1, (1 << N) - 1));
        ifc.din = (N*DATA_W)'({$urandom(), $urandom()});
        for (int f = 0; f < 12; f++) begin
            e  = model_pick(ifc.req, ptr_m);
            eg = '0;
            eg[e] = 1'b1;
            ew = ifc.din[e*DATA_W +: DATA_W];
            wait_gnt(g, ok, pb);
            total++; if (!ok || g !== eg) begin bad++; $display("FAIL rand_gnt f%0d req %b: got %b want %b", f, ifc.req, g, eg); end
            total++; if (ifc.tx_din !== ew) begin bad++; $display("FAIL rand_tx_din f%0d: got %h want %h", f, ifc.tx_din, ew); end
            total++; if (pb !== 1'b0) begin bad++; $display("FAIL rand_gnt_while_busy f%0d: busy %b want 0", f, pb); end
            ptr_m   = (e + 1) % N;
            ifc.req = (f == 11) ? '0 : N'($urandom_range(1, (1 << N) - 1));
            ifc.din = (N*DATA_W)'({$urandom(), $urandom()});
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_idle: busy %b want 0", ifc.busy); end
    endtask

    task automatic test_baud_pending();
        logic [N-1:0] g;
        logic pb;
        bit ok;
        bit held;
        ifc.req = 4'b0001;
        wait_gnt(g, ok, pb);
        total++; if (!ok || g !== 4'b0001) begin bad++; $display("FAIL pend_gnt: got %b want 0001", g); end
        ptr_m   = 1;
        ifc.req = '0;
        @(negedge clk);
        ifc.baud_cfg = 20'd32;
        ifc.baud_ld  = 1'b1;
        @(negedge clk);
        ifc.baud_ld  = 1'b0;
        held = 1'b1;
        ok   = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (!ifc.busy) begin
                ok = 1'b1;
                break;
            end
            if (ifc.tx_baud !== 20'd16) held = 1'b0;
            @(negedge clk);
        end
        total++; if (!ok)   begin bad++; $display("FAIL pend_idle: busy %b want 0", ifc.busy); end
        total++; if (!held) begin bad++; $display("FAIL pend_held: tx_baud changed mid-frame, want 16"); end
        total++; if (ifc.tx_baud !== 20'd32) begin bad++; $display("FAIL pend_apply: got %0d want 32", ifc.tx_baud); end
        total++; if (ifc.baud_err !== 1'b0)  begin bad++; $display("FAIL pend_err: got %b want 0", ifc.baud_err); end
    endtask

    task automatic test_abort();
        logic [N-1:0] g, eg;
        logic pb;
        bit ok;
        bit seen;
        int e;
        ifc.req = 4'b0100;
        e  = model_pick(ifc.req, ptr_m);
        eg = '0;
        eg[e] = 1'b1;
        wait_gnt(g, ok, pb);
        total++; if (!ok || g !== eg) begin bad++; $display("FAIL abort_gnt: got %b want %b", g, eg); end
        ptr_m = (e + 1) % N;
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (ifc.tx_set && ifc.bit_cnt == 10'd5) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL abort_reach5: bit_cnt %0d want 5", ifc.bit_cnt); end
        ifc.enable = 1'b0;
        @(negedge clk);
        total++; if (ifc.tx_set !== 1'b0 || ifc.busy !== 1'b1) begin
            bad++; $display("FAIL abort_gap: tx_set/busy %b%b want 01", ifc.tx_set, ifc.busy);
        end
        total++; if (ifc.tx_sel !== 1'b0) begin bad++; $display("FAIL abort_tx_sel: got %b want 0", ifc.tx_sel); end
        @(negedge clk);
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL abort_idle: busy %b want 0", ifc.busy); end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.gnt != '0 || ifc.busy) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_no_regrant: got grant/busy want none"); end
        ifc.req    = '0;
        ifc.enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g, eg;
        logic pb;
        bit ok;
        bit seen;
        int e;
        ifc.req = 4'b0010;
        e  = model_pick(ifc.req, ptr_m);
        eg = '0;
        eg[e] = 1'b1;
        wait_gnt(g, ok, pb);
        total++; if (!ok || g !== eg) begin bad++; $display("FAIL rmid_gnt: got %b want %b", g, eg); end
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (ifc.tx_set && ifc.bit_cnt == 10'd2) begin
                ok = 1'b1;
                break;
            end
        end
        ifc.baud_cfg = 20'd20;
        ifc.baud_ld  = 1'b1;
        @(negedge clk);
        ifc.baud_ld  = 1'b0;
        for (int c = 0; c < BUDGET && ok; c++) begin
            if (ifc.tx_set && ifc.bit_cnt == 10'd7) break;
            if (c == BUDGET - 1) ok = 1'b0;
            @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL rmid_reach7: bit_cnt %0d want 7", ifc.bit_cnt); end
        rst = 1'b1;
        #1;
        total++; if (ifc.tx_set !== 1'b0) begin bad++; $display("FAIL rmid_tx_set: got %b want 0", ifc.tx_set); end
        total++; if (ifc.busy !== 1'b0)   begin bad++; $display("FAIL rmid_busy: got %b want 0", ifc.busy); end
        total++; if (ifc.gnt !== '0)      begin bad++; $display("FAIL rmid_gnt0: got %b want 0", ifc.gnt); end
        total++; if (ifc.tx_baud !== '0)  begin bad++; $display("FAIL rmid_baud: got %0d want 0", ifc.tx_baud); end
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ifc.gnt != '0 || ifc.busy) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL rmid_no_gnt: got grant want none"); end
        total++; if (ifc.tx_baud !== '0) begin bad++; $display("FAIL rmid_pend_dropped: got %0d want 0", ifc.tx_baud); end
        load_baud(20'd16);
        e  = model_pick(ifc.req, ptr_m);
        eg = '0;
        eg[e] = 1'b1;
        @(negedge clk);
        total++; if (ifc.gnt !== eg) begin bad++; $display("FAIL rmid_regrant: got %b want %b", ifc.gnt, eg); end
        ptr_m   = (e + 1) % N;
        ifc.req = '0;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_idle: busy %b want 0", ifc.busy); end
    endtask

    initial begin : main
        total = 0;
        bad   = 0;
        ptr_m = 0;
        test_reset();
        test_baud_err();
        test_round_robin();
        test_wrap();
        test_random();
        test_baud_pending();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
